// File: rtl/knight_trail_pkg.sv
// Shared constants for the knight flasher afterglow stage.
// Brightness levels run 0..LEVEL_MAX and the PWM period is LEVEL_MAX cycles.
package knight_trail_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int BW_DEFAULT    = 3;
  localparam int DECAY_DEFAULT = 2;

  function automatic int level_max(input int bw);
    return (1 << bw) - 1;
  endfunction

  localparam int LEVEL_MAX  = level_max(BW_DEFAULT);
  localparam int PWM_PERIOD = LEVEL_MAX;

endpackage

// File: rtl/knight_trail_cell.sv
// One LED slice: brightness level register with saturating decay, and the
// registered PWM comparator that drives the pin.
module knight_trail_cell
  import knight_trail_pkg::*;
#(
  parameter int BW    = BW_DEFAULT,
  parameter int DECAY = DECAY_DEFAULT
) (
  input  logic          ck,
  input  logic          res,
  input  logic          step,
  input  logic          pos_i,
  input  logic [BW-1:0] pwm_cnt,
  output logic          led_i
);

  localparam logic [BW-1:0] LMAX = BW'(level_max(BW));
  localparam logic [BW-1:0] DEC  = BW'(DECAY);

  logic [BW-1:0] r_level;
  logic [BW-1:0] w_level_nxt;
  logic          r_led;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_level_nxt = r_level;
    if (step) begin
      if (pos_i)              w_level_nxt = LMAX;
      else if (r_level > DEC) w_level_nxt = r_level - DEC;
      else                    w_level_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_level <= '0;
      r_led   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_led   <= (r_level > pwm_cnt);
    end
  end

  assign led_i = r_led;

endmodule

// File: rtl/knight_trail.sv
// Afterglow trail for the knight flasher: per-LED fading brightness driven
// through a shared free-running PWM counter, with a per-period frame pulse.
module knight_trail
  import knight_trail_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int BW    = BW_DEFAULT,
  parameter int DECAY = DECAY_DEFAULT
) (
  input  logic         ck,
  input  logic         res,
  input  logic         step,
  input  logic [N-1:0] pos,
  output logic [N-1:0] led,
  output logic         frame
);

  localparam logic [BW-1:0] CNT_LAST = BW'(level_max(BW) - 1);

  logic [BW-1:0] r_pwm_cnt;
  logic          r_frame;
  logic          w_cnt_last;

  assign w_cnt_last = (r_pwm_cnt == CNT_LAST);

  // Counter wraps one short of the all-ones value so a full level stays lit every slot.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_pwm_cnt <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_frame   <= w_cnt_last;
      r_pwm_cnt <= w_cnt_last ? '0 : r_pwm_cnt + 1'b1;
    end
  end

  assign frame = r_frame;

  for (genvar g = 0; g < N; g++) begin : g_cell
    knight_trail_cell #(
      .BW    (BW),
      .DECAY (DECAY)
    ) u_cell (
      .ck      (ck),
      .res     (res),
      .step    (step),
      .pos_i   (pos[g]),
      .pwm_cnt (r_pwm_cnt),
      .led_i   (led[g])
    );
  end

endmodule

// File: tb/tb_knight_trail.sv
// Self-checking bench for knight_trail: randomized stimulus against a
// level/duty reference model, plus directed duty and reset scenarios.
module tb_knight_trail;

  localparam int N      = 8;
  localparam int LMAX   = 7;
  localparam int DECAY  = 2;
  localparam int PERIOD = 7;

  logic         ck = 1'b0;
  logic         res;
  logic         step;
  logic [N-1:0] pos;
  logic [N-1:0] led;
  logic         frame;

  knight_trail dut (
    .ck    (ck),
    .res   (res),
    .step  (step),
    .pos   (pos),
    .led   (led),
    .frame (frame)
  );

  always #5 ck = ~ck;

  int checks   = 0;
  int failures = 0;

  // Reference model: brightness per LED and cycles elapsed since reset release.
  int           lvl [N];
  int           t;
  logic [N-1:0] exp_led;
  logic         exp_frame;

  task automatic model_reset();
    for (int i = 0; i < N; i++) lvl[i] = 0;
    t         = 0;
    exp_led   = '0;
    exp_frame = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input logic s, input logic [N-1:0] p);
    int phase;
    step = s;
    pos  = p;
    @(posedge ck);
    phase = t % PERIOD;
    for (int i = 0; i < N; i++) exp_led[i] = (lvl[i] > phase);
    exp_frame = (phase == PERIOD - 1);
    if (s) begin
      for (int i = 0; i < N; i++)
        lvl[i] = p[i] ? LMAX : ((lvl[i] > DECAY) ? lvl[i] - DECAY : 0);
    end
    t++;
    @(negedge ck);
  endtask

  function automatic logic [N-1:0] rand_head();
    logic [N-1:0] v;
    v = '0;
    if ($urandom_range(0, 3) != 0) v[$urandom_range(0, N - 1)] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    int first;
    res  = 1'b1;
    step = 1'b0;
    pos  = '0;
    model_reset();
    @(negedge ck);
    @(negedge ck);
    checks++;
    if (led !== 8'h00 || frame !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: led=%h frame=%b, want led=00 frame=0", led, frame);
    end
    res = 1'b0;
    for (int k = 0; k < 12; k++) cycle(1'b1, 8'($urandom));
    // Asynchronous assertion between edges.
    #2 res = 1'b1;
    #1;
    checks++;
    if (led !== 8'h00 || frame !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: led=%h frame=%b, want led=00 frame=0", led, frame);
    end
    @(negedge ck);
    res = 1'b0;
    model_reset();
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 8'($urandom));
      checks++;
      if (led !== 8'h00) begin
        failures++;
        $display("FAIL reset_led_dark: cycle %0d led=%h, want 00", k, led);
      end
      if (frame === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != 7) begin
      failures++;
      $display("FAIL reset_first_frame: first frame at cycle %0d, want 7", first);
    end
  endtask

  task automatic test_head_load();
    cycle(1'b1, 8'h01);
    checks++;
    if (lvl[0] != LMAX) begin
      failures++;
      $display("FAIL head_model_level: level0=%0d, want 7", lvl[0]);
    end
    for (int k = 0; k < 2 * PERIOD; k++) begin
      cycle(1'b0, 8'($urandom));
      checks++;
      if (led !== 8'h01) begin
        failures++;
        $display("FAIL head_led: cycle %0d led=%h, want 01", k, led);
      end
    end
  endtask

  task automatic test_decay_duty();
    int on0, on1;
    cycle(1'b1, 8'h02);
    on0 = 0;
    on1 = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cycle(1'b0, 8'h00);
      on0 += int'(led[0]);
      on1 += int'(led[1]);
      checks++;
      if (led !== exp_led) begin
        failures++;
        $display("FAIL duty_model: cycle %0d led=%h, want %h", k, led, exp_led);
      end
    end
    checks++;
    if (on0 != 5 || on1 != 7) begin
      failures++;
      $display("FAIL duty_counts: led0 on %0d, led1 on %0d, want 5 and 7", on0, on1);
    end
  endtask

  task automatic test_saturation();
    int want [5] = '{5, 3, 1, 0, 0};
    int on1;
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, 8'h00);
      on1 = 0;
      for (int k = 0; k < PERIOD; k++) begin
        cycle(1'b0, 8'h00);
        on1 += int'(led[1]);
      end
      checks++;
      if (on1 != want[s]) begin
        failures++;
        $display("FAIL sat_duty: step %0d led1 on %0d of 7, want %0d", s, on1, want[s]);
      end
    end
  endtask

  task automatic test_gating();
    int on34;
    cycle(1'b1, 8'h18);
    cycle(1'b0, 8'($urandom));
    on34 = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 8'($urandom));
      if (led[3] && led[4]) on34++;
      checks++;
      if (led !== exp_led) begin
        failures++;
        $display("FAIL gate_model: cycle %0d led=%h, want %h", k, led, exp_led);
      end
    end
    checks++;
    if (on34 != 20) begin
      failures++;
      $display("FAIL gate_hold: led3/4 both on %0d of 20, want 20", on34);
    end
    cycle(1'b1, 8'hFF);
    for (int k = 0; k < PERIOD; k++) begin
      cycle(1'b0, 8'h00);
      checks++;
      if (led !== 8'hFF) begin
        failures++;
        $display("FAIL all_on: cycle %0d led=%h, want ff", k, led);
      end
    end
  endtask

  task automatic test_back_to_back();
    int frames, exp_frames;
    frames     = 0;
    exp_frames = 0;
    for (int k = 0; k < 50; k++) begin
      cycle(1'b1, rand_head());
      frames     += int'(frame);
      exp_frames += int'(exp_frame);
      checks++;
      if (led !== exp_led || frame !== exp_frame) begin
        failures++;
        $display("FAIL b2b: cycle %0d led=%h frame=%b, want %h %b", k, led, frame, exp_led, exp_frame);
      end
    end
    checks++;
    if (frames != exp_frames) begin
      failures++;
      $display("FAIL b2b_frames: saw %0d, want %0d", frames, exp_frames);
    end
    // Steps only in the cycle the frame pulse is visible.
    frames = 0;
    for (int k = 0; k < 5 * PERIOD; k++) begin
      cycle(frame, rand_head());
      frames += int'(frame);
      checks++;
      if (led !== exp_led || frame !== exp_frame) begin
        failures++;
        $display("FAIL coincide: cycle %0d led=%h frame=%b, want %h %b", k, led, frame, exp_led, exp_frame);
      end
    end
    checks++;
    if (frames != 5) begin
      failures++;
      $display("FAIL coincide_frames: saw %0d, want 5", frames);
    end
  endtask

  initial begin
    test_reset();
    test_head_load();
    test_decay_duty();
    test_saturation();
    test_gating();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
